// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// Port ids, arbitration modes and the memory request bundle.
package dmem_arb_pkg;

    typedef enum logic {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } port_e;

    localparam int ARB_RR   = 0;
    localparam int ARB_PRIO = 1;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // In range, and not a write that would touch no bytes.
    function automatic logic req_legal(
        input mem_req_t    r,
        input logic [31:0] words
    );
        return ({2'b00, r.addr[31:2]} < words)
            && !(r.we && r.be == 4'b0000);
    endfunction

endpackage

// File: rtl/dmem_arb_arb2_core.sv
// Two-way grant logic: round-robin, or C-priority with a
// starvation counter that eventually forces D through.
module arb2_core
    import dmem_arb_pkg::*;
#(
    parameter int ARB_MODE = ARB_RR,
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic c_req,
    input  logic d_req,
    output logic c_gnt,
    output logic d_gnt
);

    localparam int WW =
        (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

    port_e         last_grant;
    logic [WW-1:0] wait_cnt;
    logic          d_wins;

    always_comb begin
        if (ARB_MODE == ARB_PRIO) begin
            d_wins = (wait_cnt == WMAX);
        end else begin
            d_wins = (last_grant == PORT_C);
        end
    end

    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        unique case (1'b1)
            c_req && !d_req: c_gnt = 1'b1;
            d_req && !c_req: d_gnt = 1'b1;
            c_req && d_req: begin
                d_gnt = d_wins;
                c_gnt = !d_wins;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PORT_D;
            wait_cnt   <= '0;
        end else begin
            if (c_gnt) begin
                last_grant <= PORT_C;
            end else if (d_gnt) begin
                last_grant <= PORT_D;
            end
            // Counts consecutive cycles D is left waiting.
            if (ARB_MODE != ARB_PRIO || !d_req || d_gnt) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WMAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core (C) and
// a DMA/debug master (D); one access per cycle.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ARB_MODE   = ARB_RR,
    parameter int MAX_WAIT   = 4,
    parameter int ADDR_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [3:0]  c_be,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    output logic        c_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    mem_req_t creq;
    mem_req_t dreq;
    mem_req_t sel;
    logic     c_req_q;
    logic     d_req_q;
    logic     any_gnt;
    logic     legal;

    assign creq = '{we: c_we, be: c_be,
                    addr: c_addr, wdata: c_wdata};
    assign dreq = '{we: d_we, be: d_be,
                    addr: d_addr, wdata: d_wdata};

    // No grants while reset is held.
    assign c_req_q = c_req & rst_n;
    assign d_req_q = d_req & rst_n;

    arb2_core #(
        .ARB_MODE(ARB_MODE),
        .MAX_WAIT(MAX_WAIT)
    ) u_core (
        .clk  (clk),
        .rst_n(rst_n),
        .c_req(c_req_q),
        .d_req(d_req_q),
        .c_gnt(c_gnt),
        .d_gnt(d_gnt)
    );

    always_comb begin
        sel = '0;
        unique case (1'b1)
            c_gnt:   sel = creq;
            d_gnt:   sel = dreq;
            default: ;
        endcase
    end

    assign any_gnt  = c_gnt | d_gnt;
    assign legal    = req_legal(sel, 32'(ADDR_WORDS));
    assign mem_we   = any_gnt & sel.we & legal;
    assign mem_be   = (any_gnt && legal) ? sel.be : 4'h0;
    assign mem_addr = sel.addr;
    assign mem_wd   = sel.wdata;

    assign c_rdata = mem_rd;
    assign d_rdata = mem_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_rvalid <= 1'b0;
            c_err    <= 1'b0;
            d_rvalid <= 1'b0;
            d_err    <= 1'b0;
        end else begin
            c_rvalid <= c_gnt & legal & ~sel.we;
            c_err    <= c_gnt & ~legal;
            d_rvalid <= d_gnt & legal & ~sel.we;
            d_err    <= d_gnt & ~legal;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench: instance 0 round-robin, instance 1 C-priority;
// both checked every cycle against a reference model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } rq_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rq_t         cq [2];
    rq_t         dq [2];
    logic        c_gnt [2];
    logic        c_rvalid [2];
    logic        c_err [2];
    logic [31:0] c_rdata [2];
    logic        d_gnt [2];
    logic        d_rvalid [2];
    logic        d_err [2];
    logic [31:0] d_rdata [2];
    logic        mem_we [2];
    logic [3:0]  mem_be [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wd [2];
    logic [31:0] mem_rd [2];

    // Instance k runs with ARB_MODE = k.
    for (genvar k = 0; k < 2; k++) begin : g_dut
        dmem_arbiter #(
            .ARB_MODE  (k),
            .MAX_WAIT  (4),
            .ADDR_WORDS(256)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .c_req   (cq[k].req),
            .c_we    (cq[k].we),
            .c_be    (cq[k].be),
            .c_addr  (cq[k].addr),
            .c_wdata (cq[k].wdata),
            .c_gnt   (c_gnt[k]),
            .c_rvalid(c_rvalid[k]),
            .c_rdata (c_rdata[k]),
            .c_err   (c_err[k]),
            .d_req   (dq[k].req),
            .d_we    (dq[k].we),
            .d_be    (dq[k].be),
            .d_addr  (dq[k].addr),
            .d_wdata (dq[k].wdata),
            .d_gnt   (d_gnt[k]),
            .d_rvalid(d_rvalid[k]),
            .d_rdata (d_rdata[k]),
            .d_err   (d_err[k]),
            .mem_we  (mem_we[k]),
            .mem_be  (mem_be[k]),
            .mem_addr(mem_addr[k]),
            .mem_wd  (mem_wd[k]),
            .mem_rd  (mem_rd[k])
        );
    end

    // Memory slaves: byte writes, registered read.
    logic [31:0] ram [2][256];
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[k] && mem_be[k][b]) begin
                    ram[k][mem_addr[k][9:2]][8*b +: 8] <=
                        mem_wd[k][8*b +: 8];
                end
            end
            mem_rd[k] <= ram[k][mem_addr[k][9:2]];
        end
    end

    // Reference model state.
    logic        ref_last [2];
    int          ref_wait [2];
    logic [31:0] shadow [2][256];
    logic [3:0]  sv [2][256];
    logic        pc_rv [2];
    logic        pc_er [2];
    logic        pd_rv [2];
    logic        pd_er [2];
    logic [31:0] pdata [2];
    logic [3:0]  pmask [2];
    logic        obs_cg [2];
    logic        obs_dg [2];
    logic [31:0] last_rd [2];
    logic [5:0]  seq [2];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input int k, input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h want %h",
                     tag, k, got, exp);
        end
    endtask

    task automatic model_check(input int k);
        logic        cr, dr, gc, gd, lg, any;
        logic [31:0] m32, got;
        logic [7:0]  w;
        rq_t         r;
        cr = cq[k].req;
        dr = dq[k].req;
        if (cr && dr) begin
            if (k == ARB_RR) gd = (ref_last[k] == 1'b0);
            else             gd = (ref_wait[k] == 4);
            gc = !gd;
        end else begin
            gc = cr;
            gd = dr;
        end
        any = gc | gd;
        chk(k, "c_gnt", 32'(c_gnt[k]), 32'(gc));
        chk(k, "d_gnt", 32'(d_gnt[k]), 32'(gd));
        r  = gc ? cq[k] : (gd ? dq[k] : '0);
        lg = (r.addr < 32'h400) && !(r.we && r.be == 4'h0);
        chk(k, "mem_we", 32'(mem_we[k]),
            32'(any && r.we && lg));
        chk(k, "mem_be", 32'(mem_be[k]),
            32'((any && lg) ? r.be : 4'h0));
        chk(k, "mem_addr", mem_addr[k], r.addr);
        chk(k, "mem_wd", mem_wd[k], r.wdata);
        chk(k, "c_rvalid", 32'(c_rvalid[k]), 32'(pc_rv[k]));
        chk(k, "c_err", 32'(c_err[k]), 32'(pc_er[k]));
        chk(k, "d_rvalid", 32'(d_rvalid[k]), 32'(pd_rv[k]));
        chk(k, "d_err", 32'(d_err[k]), 32'(pd_er[k]));
        if (pc_rv[k] || pd_rv[k]) begin
            for (int b = 0; b < 4; b++) begin
                m32[8*b +: 8] = {8{pmask[k][b]}};
            end
            got = pc_rv[k] ? c_rdata[k] : d_rdata[k];
            chk(k, "rdata", got & m32, pdata[k] & m32);
        end
        if (c_rvalid[k]) last_rd[k] = c_rdata[k];
        else if (d_rvalid[k]) last_rd[k] = d_rdata[k];
        // Predict next cycle's responses and memory contents.
        w = r.addr[9:2];
        pc_rv[k] = gc && lg && !r.we;
        pc_er[k] = gc && !lg;
        pd_rv[k] = gd && lg && !r.we;
        pd_er[k] = gd && !lg;
        pdata[k] = shadow[k][w];
        pmask[k] = sv[k][w];
        if (any && lg && r.we) begin
            for (int b = 0; b < 4; b++) begin
                if (r.be[b]) begin
                    shadow[k][w][8*b +: 8] = r.wdata[8*b +: 8];
                    sv[k][w][b] = 1'b1;
                end
            end
        end
        if (any) ref_last[k] = gd;
        if (dr && !gd) begin
            ref_wait[k] = (ref_wait[k] < 4) ? ref_wait[k] + 1 : 4;
        end else begin
            ref_wait[k] = 0;
        end
        obs_cg[k] = c_gnt[k];
        obs_dg[k] = d_gnt[k];
    endtask

    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) model_check(k);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cq[k]       = '0;
            dq[k]       = '0;
            pc_rv[k]    = 1'b0;
            pc_er[k]    = 1'b0;
            pd_rv[k]    = 1'b0;
            pd_er[k]    = 1'b0;
            ref_last[k] = 1'b1;
            ref_wait[k] = 0;
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            chk(k, "rst_c_rvalid", 32'(c_rvalid[k]), 0);
            chk(k, "rst_d_err", 32'(d_err[k]), 0);
            chk(k, "rst_gnt", 32'({c_gnt[k], d_gnt[k]}), 0);
            chk(k, "rst_mem_be", 32'(mem_be[k]), 0);
            chk(k, "rst_mem_addr", mem_addr[k], 0);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic rq_t mk(input logic we,
                               input logic [3:0] be,
                               input logic [31:0] a,
                               input logic [31:0] d);
        return '{req: 1'b1, we: we, be: be, addr: a, wdata: d};
    endfunction

    task automatic drive(input rq_t c, input rq_t d);
        for (int k = 0; k < 2; k++) begin
            cq[k] = c;
            dq[k] = d;
        end
    endtask

    function automatic rq_t rnd();
        rq_t r;
        r.req   = ($urandom_range(0, 3) != 0);
        r.we    = 1'($urandom_range(0, 1));
        r.be    = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
        r.addr  = ($urandom_range(0, 9) == 0) ? $urandom :
                  {26'b0, 4'($urandom_range(0, 15)), 2'($urandom)};
        r.wdata = $urandom;
        return r;
    endfunction

    initial begin
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            last_rd[k] = '0;
            seq[k]     = '0;
            obs_cg[k]  = 1'b0;
            obs_dg[k]  = 1'b0;
            for (int i = 0; i < 256; i++) sv[k][i] = 4'h0;
        end
        #1;
        do_reset();

        // Write then read back one word.
        drive(mk(1'b1, 4'hF, 32'h10, 32'hDEADBEEF), '0);
        step();
        drive(mk(1'b0, 4'hF, 32'h10, 32'h0), '0);
        step();
        drive('0, '0);
        step();
        for (int k = 0; k < 2; k++)
            chk(k, "t1_rdata", last_rd[k], 32'hDEADBEEF);

        // Both ports hold reads: grant order per mode.
        do_reset();
        drive(mk(1'b0, 4'hF, 32'h0, 32'h0),
              mk(1'b0, 4'hF, 32'h4, 32'h0));
        for (int i = 0; i < 6; i++) begin
            step();
            for (int k = 0; k < 2; k++) seq[k][i] = obs_dg[k];
        end
        drive('0, '0);
        step();
        chk(0, "t2_seq", 32'(seq[0][3:0]), 32'h0000000A);
        chk(1, "t3_seq", 32'(seq[1]), 32'h00000010);

        // Empty-byte write and out-of-range read from D.
        drive('0, mk(1'b1, 4'h0, 32'h40, 32'h12345678));
        step();
        drive('0, mk(1'b0, 4'hF, 32'h400, 32'h0));
        step();
        drive('0, '0);
        step();

        // Partial byte write merges into the old word.
        drive(mk(1'b1, 4'hF, 32'h20, 32'h11223344), '0);
        step();
        drive(mk(1'b1, 4'b0010, 32'h20, 32'h0000AB00), '0);
        step();
        drive(mk(1'b0, 4'hF, 32'h20, 32'h0), '0);
        step();
        drive('0, '0);
        step();
        for (int k = 0; k < 2; k++)
            chk(k, "t5_rdata", last_rd[k], 32'h1122AB44);

        // Reset lands between a read grant and its response.
        drive(mk(1'b0, 4'hF, 32'h10, 32'h0), '0);
        @(negedge clk);
        for (int k = 0; k < 2; k++) model_check(k);
        do_reset();
        step();
        drive(mk(1'b0, 4'hF, 32'h0, 32'h0),
              mk(1'b0, 4'hF, 32'h4, 32'h0));
        step();
        for (int k = 0; k < 2; k++)
            chk(k, "t6_c_first", 32'(obs_cg[k]), 1);
        drive('0, '0);
        step();

        // Random traffic; requests are held until granted.
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < 2; k++) begin
                if (!cq[k].req || obs_cg[k]) cq[k] = rnd();
                if (!dq[k].req || obs_dg[k]) dq[k] = rnd();
            end
            step();
        end
        drive('0, '0);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
